// File: rtl/sccb_target_if.sv
// SCCB bus wires between a master and the camera-side register target.
// sio_d is the resolved open-drain wire; the target only ever pulls it low via sio_d_oe.
interface sccb_target_if;
  logic sio_c;
  logic sio_d;
  logic sio_d_oe;

  modport master (output sio_c, output sio_d, input sio_d_oe);
  modport slave  (input sio_c, input sio_d, output sio_d_oe);
endinterface

// File: rtl/sccb_target.sv
// SCCB register target: oversamples the bus on clk_24, decodes 3-phase writes and
// 2-phase write + 2-phase read transactions, and acks/reads by pulling sio_d low.
module sccb_target #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic          clk_24,
  input  logic          reset,
  sccb_target_if.slave  sccb,
  output logic [7:0]    reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_wr,
  input  logic [7:0]    reg_rdata,
  output logic          busy,
  output logic          id_miss
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic                   c_prev;
  logic                   d_prev;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_shift;
  logic [6:0]             tx_shift;
  logic                   ack_phase;
  logic                   rw;
  logic                   rd_last;

  logic       c_s;
  logic       d_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] byte_in;

  // Synchronizers and history flops preset high so reset looks like an idle bus.
  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
      d_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], sccb.sio_c};
      d_sync <= {d_sync[SYNC_STAGES-2:0], sccb.sio_d};
      c_prev <= c_sync[SYNC_STAGES-1];
      d_prev <= d_sync[SYNC_STAGES-1];
    end
  end

  assign c_s       = c_sync[SYNC_STAGES-1];
  assign d_s       = d_sync[SYNC_STAGES-1];
  assign scl_rise  = c_s & ~c_prev;
  assign scl_fall  = ~c_s & c_prev;
  // START/STOP need scl high on both samples so a simultaneous scl fall never qualifies.
  assign start_det = c_s & c_prev & ~d_s & d_prev;
  assign stop_det  = c_s & c_prev & d_s & ~d_prev;
  assign byte_in   = {rx_shift, d_s};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_24 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx_shift      <= 7'd0;
      tx_shift      <= 7'd0;
      ack_phase     <= 1'b0;
      rw            <= 1'b0;
      rd_last       <= 1'b0;
      sccb.sio_d_oe <= 1'b0;
      reg_addr      <= 8'd0;
      reg_wdata     <= 8'd0;
      reg_wr        <= 1'b0;
      id_miss       <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      id_miss <= 1'b0;
      if (start_det) begin
        state         <= ID;
        bit_cnt       <= 3'd0;
        sccb.sio_d_oe <= 1'b0;
      end else if (stop_det) begin
        state         <= IDLE;
        sccb.sio_d_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ID, SUB, WDATA: begin
            if (scl_rise) begin
              rx_shift <= byte_in[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_phase <= 1'b0;
                if (state == ID) begin
                  if (byte_in[7:1] == DEVICE_ID[7:1]) begin
                    rw    <= byte_in[0];
                    state <= ID_ACK;
                  end else begin
                    id_miss <= 1'b1;
                    state   <= IGNORE;
                  end
                end else if (state == SUB) begin
                  reg_addr <= byte_in;
                  state    <= SUB_ACK;
                end else begin
                  reg_wdata <= byte_in;
                  reg_wr    <= 1'b1;
                  state     <= WDATA_ACK;
                end
              end
            end
          end
          // First scl fall drives the ack, the second releases it and moves on.
          ID_ACK, SUB_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sccb.sio_d_oe <= 1'b1;
                ack_phase     <= 1'b1;
              end else begin
                ack_phase     <= 1'b0;
                bit_cnt       <= 3'd0;
                sccb.sio_d_oe <= 1'b0;
                if (state == ID_ACK && rw) begin
                  state         <= RDATA;
                  tx_shift      <= reg_rdata[6:0];
                  sccb.sio_d_oe <= ~reg_rdata[7];
                  rd_last       <= 1'b0;
                end else if (state == ID_ACK) begin
                  state <= SUB;
                end else if (state == SUB_ACK) begin
                  state <= WDATA;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              if (bit_cnt == 3'd7) rd_last <= 1'b1;
              else                 bit_cnt <= bit_cnt + 3'd1;
            end else if (scl_fall) begin
              if (rd_last) begin
                sccb.sio_d_oe <= 1'b0;
                state         <= RD_NA;
              end else begin
                sccb.sio_d_oe <= ~tx_shift[6];
                tx_shift      <= {tx_shift[5:0], 1'b0};
              end
            end
          end
          RD_NA: begin
            if (scl_rise) state <= IGNORE;
          end
          IGNORE: sccb.sio_d_oe <= 1'b0;
          default: begin
            state         <= IDLE;
            sccb.sio_d_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
